// File: rtl/activation_pkg.sv
// Shared types and constants for the multi-lane activation stage.
// Holds the mode encodings, the counter width and the saturating add helper.
package activation_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_RELU  = 2'd1,
    MODE_LEAKY = 2'd2,
    MODE_CLIP  = 2'd3
  } act_mode_e;

  localparam int unsigned COUNT_WIDTH = 32;

  function automatic logic [COUNT_WIDTH-1:0] sat_add(logic [COUNT_WIDTH-1:0] a,
                                                      logic [COUNT_WIDTH-1:0] b);
    logic [COUNT_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[COUNT_WIDTH] ? '1 : sum[COUNT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/activation_unit_if.sv
// FIFO-facing handshake, mode and counter signals of the activation stage.
// The slave modport is the DUT view; master is the environment view.
interface activation_unit_if #(
  parameter int unsigned DWIDTH_IN  = 16,
  parameter int unsigned DWIDTH_OUT = 16,
  parameter int unsigned CHANNELS   = 1
);
  import activation_pkg::*;

  logic [1:0]                     mode;
  logic [CHANNELS*DWIDTH_IN-1:0]  fifo_in_dout;
  logic                           fifo_in_empty;
  logic                           fifo_in_rd_en;
  logic [CHANNELS*DWIDTH_OUT-1:0] fifo_out_din;
  logic                           fifo_out_wr_en;
  logic                           fifo_out_full;
  logic                           count_clear;
  logic [COUNT_WIDTH-1:0]         clip_count;

  modport master (
    output mode, fifo_in_dout, fifo_in_empty, fifo_out_full, count_clear,
    input  fifo_in_rd_en, fifo_out_din, fifo_out_wr_en, clip_count
  );

  modport slave (
    input  mode, fifo_in_dout, fifo_in_empty, fifo_out_full, count_clear,
    output fifo_in_rd_en, fifo_out_din, fifo_out_wr_en, clip_count
  );

endinterface

// File: rtl/activation_lane.sv
// Combinational single-lane activation followed by signed saturation to DWIDTH_OUT.
// clamp flags lanes changed by the CLIP_MAX bound or by output saturation.
module activation_lane
  import activation_pkg::*;
#(
  parameter int unsigned DWIDTH_IN  = 16,
  parameter int unsigned DWIDTH_OUT = 16,
  parameter int unsigned LEAK_SHIFT = 3,
  parameter int unsigned CLIP_MAX   = 255
) (
  input  act_mode_e                    mode,
  input  logic signed [DWIDTH_IN-1:0]  x,
  output logic signed [DWIDTH_OUT-1:0] y,
  output logic                         clamp
);

  // Working width holds any input, output bound and the 32-bit CLIP_MAX without overflow.
  localparam int unsigned WMax = (DWIDTH_IN > DWIDTH_OUT) ? DWIDTH_IN : DWIDTH_OUT;
  localparam int unsigned EW   = ((WMax > 32) ? WMax : 32) + 1;

  localparam logic signed [EW-1:0] ClipMax = EW'(CLIP_MAX);
  localparam logic signed [EW-1:0] OutMax  =
    {{(EW-DWIDTH_OUT+1){1'b0}}, {(DWIDTH_OUT-1){1'b1}}};
  localparam logic signed [EW-1:0] OutMin  =
    {{(EW-DWIDTH_OUT+1){1'b1}}, {(DWIDTH_OUT-1){1'b0}}};

  logic signed [EW-1:0] xe;
  logic signed [EW-1:0] ye;
  logic signed [EW-1:0] sat;
  logic                 clip_hit;
  logic                 sat_hit;

  always_comb begin
    xe       = {{(EW-DWIDTH_IN){x[DWIDTH_IN-1]}}, x};
    ye       = xe;
    clip_hit = 1'b0;
    unique case (mode)
      MODE_PASS:  ye = xe;
      MODE_RELU:  ye = xe[EW-1] ? '0 : xe;
      MODE_LEAKY: ye = xe[EW-1] ? (xe >>> LEAK_SHIFT) : xe;
      MODE_CLIP: begin
        if (xe[EW-1]) begin
          ye = '0;
        end else if (xe > ClipMax) begin
          ye       = ClipMax;
          clip_hit = 1'b1;
        end
      end
      default:    ye = xe;
    endcase
  end

  always_comb begin
    sat     = ye;
    sat_hit = 1'b0;
    if (ye > OutMax) begin
      sat     = OutMax;
      sat_hit = 1'b1;
    end else if (ye < OutMin) begin
      sat     = OutMin;
      sat_hit = 1'b1;
    end
  end

  assign y     = sat[DWIDTH_OUT-1:0];
  assign clamp = clip_hit | sat_hit;

endmodule

// File: rtl/activation_unit.sv
// Two-stage stallable activation pipeline between two FWFT FIFOs, CHANNELS lanes per word,
// with a saturating count of clamped lanes accepted by the output FIFO.
module activation_unit
  import activation_pkg::*;
#(
  parameter int unsigned DWIDTH_IN  = 16,
  parameter int unsigned DWIDTH_OUT = 16,
  parameter int unsigned CHANNELS   = 1,
  parameter int unsigned LEAK_SHIFT = 3,
  parameter int unsigned CLIP_MAX   = 255
) (
  input logic             clock,
  input logic             reset,
  activation_unit_if.slave bus
);

  logic                           s1_valid;
  logic [CHANNELS*DWIDTH_IN-1:0]  s1_data;
  act_mode_e                      s1_mode;
  logic                           s2_valid;
  logic [CHANNELS*DWIDTH_OUT-1:0] s2_data;
  logic [CHANNELS-1:0]            s2_clamp;
  logic [COUNT_WIDTH-1:0]         count_q;

  logic [CHANNELS*DWIDTH_OUT-1:0] lane_y;
  logic [CHANNELS-1:0]            lane_clamp;
  logic [COUNT_WIDTH-1:0]         clamp_cnt;
  logic                           adv;
  logic                           rd_en;
  logic                           wr_en;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    activation_lane #(
      .DWIDTH_IN (DWIDTH_IN),
      .DWIDTH_OUT(DWIDTH_OUT),
      .LEAK_SHIFT(LEAK_SHIFT),
      .CLIP_MAX  (CLIP_MAX)
    ) u_lane (
      .mode (s1_mode),
      .x    (s1_data[k*DWIDTH_IN +: DWIDTH_IN]),
      .y    (lane_y[k*DWIDTH_OUT +: DWIDTH_OUT]),
      .clamp(lane_clamp[k])
    );
  end

  assign adv   = !s2_valid || !bus.fifo_out_full;
  // Gated by reset so nothing is popped while the pipeline is held in reset.
  assign rd_en = reset && adv && !bus.fifo_in_empty;
  assign wr_en = s2_valid && !bus.fifo_out_full;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= MODE_PASS;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_clamp <= '0;
    end else if (adv) begin
      s1_valid <= rd_en;
      if (rd_en) begin
        s1_data <= bus.fifo_in_dout;
        s1_mode <= act_mode_e'(bus.mode);
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data  <= lane_y;
        s2_clamp <= lane_clamp;
      end
    end
  end

  always_comb begin
    clamp_cnt = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      clamp_cnt = clamp_cnt + COUNT_WIDTH'(s2_clamp[k]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (bus.count_clear) begin
      count_q <= '0;
    end else if (wr_en) begin
      count_q <= sat_add(count_q, clamp_cnt);
    end
  end

  assign bus.fifo_in_rd_en  = rd_en;
  assign bus.fifo_out_wr_en = wr_en;
  assign bus.fifo_out_din   = s2_data;
  assign bus.clip_count     = count_q;

endmodule

// File: tb/tb_activation_unit.sv
// Scoreboard bench: the driver pushes hand-computed results when a word is popped,
// a separate monitor pops and compares on every output FIFO write.
module tb_activation_unit;
  import activation_pkg::*;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  m;
    logic [15:0] e;
  } item_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  activation_unit_if #(.DWIDTH_IN(16), .DWIDTH_OUT(16), .CHANNELS(1)) bus ();
  activation_unit_if #(.DWIDTH_IN(16), .DWIDTH_OUT(8), .CHANNELS(4)) bus_n ();

  activation_unit #(
    .DWIDTH_IN(16), .DWIDTH_OUT(16), .CHANNELS(1), .LEAK_SHIFT(3), .CLIP_MAX(255)
  ) u_dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  activation_unit #(
    .DWIDTH_IN(16), .DWIDTH_OUT(8), .CHANNELS(4), .LEAK_SHIFT(3), .CLIP_MAX(255)
  ) u_dut_n (
    .clock(clock),
    .reset(reset),
    .bus  (bus_n)
  );

  item_t       in_q[$];
  logic [15:0] exp_q[$];
  logic [63:0] in_n_q[$];
  logic [31:0] exp_n_q[$];
  int          wr_cyc[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int wr_n_cnt = 0;
  int stall_left = 0;
  bit bp_arm = 1'b0;
  bit bp_started = 1'b0;
  int bp_base = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endfunction

  // Monitor: sampled one time unit before each rising edge.
  always @(negedge clock) begin
    #4;
    if (reset && bus.fifo_out_wr_en) begin
      if (exp_q.size() == 0) chk("unexpected_write", {48'd0, bus.fifo_out_din}, 64'hDEAD);
      else chk("out_word", {48'd0, bus.fifo_out_din}, {48'd0, exp_q.pop_front()});
      wr_cnt++;
      wr_cyc.push_back(cyc);
    end
    if (reset && bus_n.fifo_out_wr_en) begin
      if (exp_n_q.size() == 0) chk("unexpected_write_n", {32'd0, bus_n.fifo_out_din}, 64'hDEAD);
      else chk("out_word_n", {32'd0, bus_n.fifo_out_din}, {32'd0, exp_n_q.pop_front()});
      wr_n_cnt++;
    end
  end

  task automatic push(input logic [15:0] d, input logic [1:0] m, input logic [15:0] e);
    item_t it;
    it.d = d;
    it.m = m;
    it.e = e;
    in_q.push_back(it);
  endtask

  // Driver: inputs change just after the falling edge; pops are decided from rd_en.
  task automatic step();
    @(negedge clock);
    #1;
    cyc++;
    if (bp_arm && !bp_started && (wr_cnt - bp_base) >= 3) begin
      bp_started = 1'b1;
      stall_left = 5;
    end
    bus.fifo_out_full  = (stall_left > 0);
    bus.fifo_in_empty  = (in_q.size() == 0);
    if (in_q.size() != 0) begin
      bus.fifo_in_dout = in_q[0].d;
      bus.mode         = in_q[0].m;
    end
    bus_n.fifo_in_empty = (in_n_q.size() == 0);
    if (in_n_q.size() != 0) bus_n.fifo_in_dout = in_n_q[0];
    #1;
    if (bus.fifo_in_rd_en) begin
      exp_q.push_back(in_q[0].e);
      void'(in_q.pop_front());
    end
    if (bus_n.fifo_in_rd_en) void'(in_n_q.pop_front());
    if (stall_left > 0) begin
      chk("rd_en_during_stall", {63'd0, bus.fifo_in_rd_en}, 64'd0);
      stall_left--;
    end
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0 || in_n_q.size() != 0 ||
            exp_n_q.size() != 0) && n < limit) begin
      step();
      n++;
    end
    if (n >= limit) chk("drain_timeout", 64'(exp_q.size() + in_q.size()), 64'd0);
    repeat (3) step();
  endtask

  int base;
  logic [15:0] x;
  int gaps[9] = '{1, 1, 6, 1, 1, 1, 1, 1, 1};

  initial begin
    bus.fifo_in_empty   = 1'b0;
    bus.fifo_in_dout    = 16'h1234;
    bus.fifo_out_full   = 1'b0;
    bus.mode            = 2'd0;
    bus.count_clear     = 1'b0;
    bus_n.fifo_in_empty = 1'b1;
    bus_n.fifo_in_dout  = '0;
    bus_n.fifo_out_full = 1'b0;
    bus_n.mode          = 2'd0;
    bus_n.count_clear   = 1'b0;

    #12;
    chk("reset_rd_en", {63'd0, bus.fifo_in_rd_en}, 64'd0);
    chk("reset_wr_en", {63'd0, bus.fifo_out_wr_en}, 64'd0);
    chk("reset_din", {48'd0, bus.fifo_out_din}, 64'd0);
    chk("reset_clip_count", {32'd0, bus.clip_count}, 64'd0);
    bus.fifo_in_empty = 1'b1;
    @(negedge clock);
    #1 reset = 1'b1;

    // ReLU sweep over every 16-bit code.
    base = wr_cnt;
    for (int i = 0; i < 65536; i++) begin
      x = 16'(i);
      push(x, 2'd1, x[15] ? 16'h0000 : x);
    end
    drain(70000);
    chk("sweep_writes", 64'(wr_cnt - base), 64'd65536);
    chk("sweep_clip_count", {32'd0, bus.clip_count}, 64'd0);

    // Leaky then clipped, back to back: each word keeps its own mode.
    push(16'hFFF8, 2'd2, 16'hFFFF);
    push(16'hFFFF, 2'd2, 16'hFFFF);
    push(16'hFFF7, 2'd2, 16'hFFFE);
    push(16'h0064, 2'd2, 16'h0064);
    push(16'h012C, 2'd3, 16'h00FF);
    push(16'hFFFB, 2'd3, 16'h0000);
    push(16'h00FF, 2'd3, 16'h00FF);
    drain(100);
    chk("clip_count_after_clip", {32'd0, bus.clip_count}, 64'd1);

    // Narrow four-lane output.
    in_n_q.push_back({16'h0100, 16'hFF00, 16'h0005, 16'hFFFB});
    exp_n_q.push_back({8'h7F, 8'h80, 8'h05, 8'hFB});
    drain(100);
    chk("narrow_writes", 64'(wr_n_cnt), 64'd1);
    chk("narrow_clip_count", {32'd0, bus_n.clip_count}, 64'd2);
    bus_n.count_clear = 1'b1;
    step();
    bus_n.count_clear = 1'b0;
    chk("count_clear", {32'd0, bus_n.clip_count}, 64'd0);

    // Backpressure: output full for 5 cycles after the third write.
    base = wr_cnt;
    bp_base = wr_cnt;
    wr_cyc.delete();
    for (int i = 0; i < 10; i++) push(16'h1000 + 16'(i), 2'd0, 16'h1000 + 16'(i));
    bp_arm = 1'b1;
    drain(100);
    bp_arm = 1'b0;
    chk("bp_writes", 64'(wr_cnt - base), 64'd10);
    chk("bp_stall_seen", {63'd0, bp_started}, 64'd1);
    if (wr_cyc.size() == 10) begin
      for (int i = 1; i < 10; i++) chk("bp_write_gap", 64'(wr_cyc[i] - wr_cyc[i-1]), 64'(gaps[i-1]));
    end else begin
      chk("bp_write_cycles", 64'(wr_cyc.size()), 64'd10);
    end

    // Reset with two words in flight.
    push(16'h0AAA, 2'd0, 16'h0AAA);
    push(16'h0BBB, 2'd0, 16'h0BBB);
    for (int n = 0; n < 10 && in_q.size() != 0; n++) step();
    @(negedge clock);
    #1;
    chk("inflight_wr_en", {63'd0, bus.fifo_out_wr_en}, 64'd1);
    reset = 1'b0;
    bus.fifo_in_empty = 1'b1;
    #1;
    chk("midreset_wr_en", {63'd0, bus.fifo_out_wr_en}, 64'd0);
    chk("midreset_clip_count", {32'd0, bus.clip_count}, 64'd0);
    exp_q.delete();
    in_q.delete();
    repeat (2) @(negedge clock);
    #1 reset = 1'b1;
    base = wr_cnt;
    push(16'h0DDD, 2'd0, 16'h0DDD);
    push(16'h0EEE, 2'd0, 16'h0EEE);
    drain(100);
    chk("post_reset_writes", 64'(wr_cnt - base), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
